// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures period, high time and duty (in tenths) of an
// asynchronous PWM input, reporting a stuck level when no edge arrives in time.
module pwm_duty_decoder #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [3:0]       duty_out,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             valid,
  output logic             locked
);

  localparam int               MUL_W       = CNT_W + 4;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    STUCK   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic w_rise;

  logic [CNT_W-1:0] r_period_cnt;
  logic [CNT_W-1:0] r_high_cnt;
  logic             w_timeout;

  logic w_load;
  logic w_count;
  logic w_capture;
  logic w_stuck_report;

  logic             r_cap_valid;
  logic             r_cap_stuck;
  logic             r_cap_level;
  logic [CNT_W-1:0] r_cap_period;
  logic [CNT_W-1:0] r_cap_high;

  logic [MUL_W-1:0] w_high_x10;
  logic [9:0]       w_ge;
  logic [3:0]       w_duty;

  logic [3:0]       r_duty;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_valid;
  logic             r_locked;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= pwm_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise    = r_s2 & ~r_s3;
  assign w_timeout = (r_period_cnt == TIMEOUT_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEARCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A rise always wins over a simultaneous timeout, so a period of exactly
  // TIMEOUT cycles is still measured.
  always_comb begin
    w_state_next   = r_state;
    w_load         = 1'b0;
    w_count        = 1'b0;
    w_capture      = 1'b0;
    w_stuck_report = 1'b0;
    case (r_state)
      SEARCH, MEASURE: begin
        if (w_rise) begin
          w_load       = 1'b1;
          w_capture    = (r_state == MEASURE);
          w_state_next = MEASURE;
        end else if (w_timeout) begin
          w_stuck_report = 1'b1;
          w_state_next   = STUCK;
        end else begin
          w_count = 1'b1;
        end
      end
      STUCK: begin
        if (w_rise) begin
          w_load       = 1'b1;
          w_state_next = MEASURE;
        end
      end
      default: begin
        w_state_next = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
    end else if (w_load) begin
      r_period_cnt <= CNT_W'(1);
      r_high_cnt   <= CNT_W'(1);
    end else if (w_count) begin
      if (r_period_cnt != TIMEOUT_CNT) begin
        r_period_cnt <= r_period_cnt + 1'b1;
      end
      if (r_s2) begin
        r_high_cnt <= r_high_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_valid  <= 1'b0;
      r_cap_stuck  <= 1'b0;
      r_cap_level  <= 1'b0;
      r_cap_period <= '0;
      r_cap_high   <= '0;
    end else begin
      r_cap_valid <= w_capture | w_stuck_report;
      r_cap_stuck <= w_stuck_report;
      r_cap_level <= r_s2;
      if (w_capture) begin
        r_cap_period <= r_period_cnt;
        r_cap_high   <= r_high_cnt;
      end
    end
  end

  // Duty in tenths: count thresholds k*P (k = 1..10) that 10*H reaches.
  assign w_high_x10 = MUL_W'(r_cap_high) * MUL_W'(10);

  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_thr
      assign w_ge[gi] = (w_high_x10 >= (MUL_W'(r_cap_period) * MUL_W'(gi + 1)));
    end
  endgenerate

  always_comb begin
    w_duty = '0;
    for (int k = 0; k < 10; k++) begin
      w_duty = w_duty + {3'b000, w_ge[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty   <= '0;
      r_period <= '0;
      r_high   <= '0;
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_valid <= r_cap_valid;
      if (r_cap_valid) begin
        if (r_cap_stuck) begin
          r_duty   <= r_cap_level ? 4'd10 : 4'd0;
          r_period <= '0;
          r_high   <= '0;
          r_locked <= 1'b0;
        end else begin
          r_duty   <= w_duty;
          r_period <= r_cap_period;
          r_high   <= r_cap_high;
          r_locked <= 1'b1;
        end
      end
    end
  end

  assign duty_out   = r_duty;
  assign period_out = r_period;
  assign high_out   = r_high;
  assign valid      = r_valid;
  assign locked     = r_locked;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Scoreboard bench for pwm_duty_decoder: a sample-level model of the PWM
// waveform predicts every report; a negedge monitor checks them.
module tb_pwm_duty_decoder;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 200;
  localparam int LAT     = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pwm_in = 1'b0;
  logic [3:0]       duty_out;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             valid;
  logic             locked;

  always #5 clk = ~clk;

  pwm_duty_decoder #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .duty_out  (duty_out),
    .period_out(period_out),
    .high_out  (high_out),
    .valid     (valid),
    .locked    (locked)
  );

  typedef struct {
    int duty;
    int period;
    int high;
    bit lck;
    int cyc;
  } exp_t;

  exp_t sb[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int txn    = 0;
  bit drain_req  = 1'b0;
  bit drain_done = 1'b0;

  // Model state: 0 = waiting for first edge, 1 = measuring, 2 = stuck.
  int m_state = 0;
  int m_t     = 0;
  int m_last  = 0;
  int m_ones  = 0;
  bit m_prev  = 1'b0;

  function automatic void push_exp(input int d, input int p, input int h,
                                   input bit l, input int c);
    exp_t e;
    e.duty   = d;
    e.period = p;
    e.high   = h;
    e.lck    = l;
    e.cyc    = c;
    sb.push_back(e);
  endfunction

  function automatic void model_step(input bit lvl, input int n);
    bit rise;
    rise = lvl && !m_prev;
    if (rise) begin
      if (m_state == 1)
        push_exp((10 * m_ones) / (m_t - m_last), m_t - m_last, m_ones, 1'b1, n + LAT);
      m_state = 1;
      m_last  = m_t;
      m_ones  = 0;
    end else if (m_state == 1 && (m_t - m_last) == TIMEOUT) begin
      push_exp(lvl ? 10 : 0, 0, 0, 1'b0, n + LAT);
      m_state = 2;
    end
    if (m_state == 1 && lvl) m_ones++;
    m_prev = lvl;
    m_t++;
  endfunction

  task automatic drive_sample(input bit lvl);
    @(negedge clk);
    #1;
    pwm_in = lvl;
    model_step(lvl, cyc);
  endtask

  task automatic drive_pwm(input int per, input int hi, input int n);
    for (int p = 0; p < n; p++)
      for (int i = 0; i < per; i++)
        drive_sample(i < hi);
  endtask

  task automatic drive_level(input bit lvl, input int n);
    for (int i = 0; i < n; i++) drive_sample(lvl);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    rst    = 1'b1;
    pwm_in = 1'b0;
    sb.delete();
    m_state = 0;
    m_prev  = 1'b0;
    m_ones  = 0;
    repeat (n) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  int   last_duty   = 0;
  int   last_period = 0;
  int   last_high   = 0;
  bit   last_lck    = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (valid !== 1'b0 || locked !== 1'b0 || duty_out !== 4'd0 ||
          period_out !== '0 || high_out !== '0) begin
        errors++;
        $display("FAIL reset: valid=%0b locked=%0b duty=%0d period=%0d high=%0d, required all 0",
                 valid, locked, duty_out, period_out, high_out);
      end
      last_duty = 0; last_period = 0; last_high = 0; last_lck = 1'b0;
    end else begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        mon_e = sb.pop_front();
        $display("FAIL missing: no valid seen at cyc %0d, required duty=%0d period=%0d high=%0d",
                 mon_e.cyc, mon_e.duty, mon_e.period, mon_e.high);
      end
      if (valid === 1'b1) begin
        checks++;
        txn++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected txn%0d: valid at cyc %0d duty=%0d period=%0d high=%0d, required no valid",
                   txn, cyc, duty_out, period_out, high_out);
        end else begin
          mon_e = sb.pop_front();
          if (duty_out !== mon_e.duty[3:0] || period_out !== mon_e.period[CNT_W-1:0] ||
              high_out !== mon_e.high[CNT_W-1:0] || locked !== mon_e.lck || cyc != mon_e.cyc) begin
            errors++;
            $display("FAIL txn%0d: got duty=%0d period=%0d high=%0d locked=%0b cyc=%0d, required duty=%0d period=%0d high=%0d locked=%0b cyc=%0d",
                     txn, duty_out, period_out, high_out, locked, cyc,
                     mon_e.duty, mon_e.period, mon_e.high, mon_e.lck, mon_e.cyc);
          end else begin
            $display("txn%0d ok: duty=%0d period=%0d high=%0d locked=%0b cyc=%0d",
                     txn, duty_out, period_out, high_out, locked, cyc);
          end
          last_duty = mon_e.duty; last_period = mon_e.period;
          last_high = mon_e.high; last_lck = mon_e.lck;
        end
      end else begin
        checks++;
        if (duty_out !== last_duty[3:0] || period_out !== last_period[CNT_W-1:0] ||
            high_out !== last_high[CNT_W-1:0] || locked !== last_lck) begin
          errors++;
          $display("FAIL hold at cyc %0d: got duty=%0d period=%0d high=%0d locked=%0b, required duty=%0d period=%0d high=%0d locked=%0b",
                   cyc, duty_out, period_out, high_out, locked,
                   last_duty, last_period, last_high, last_lck);
        end
      end
    end
    if (drain_req && !drain_done) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d expected reports still pending, required 0", sb.size());
      end
      drain_done = 1'b1;
    end
  end

  initial begin
    int per;
    int hi;
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    rst = 1'b0;

    drive_pwm(10, 5, 6);
    drive_pwm(7, 3, 4);
    drive_pwm(10, 9, 4);
    drive_level(1'b1, 205);
    drive_pwm(10, 5, 3);
    drive_level(1'b0, 205);
    drive_pwm(2, 1, 5);
    drive_pwm(200, 100, 3);
    drive_pwm(201, 100, 3);
    drive_pwm(10, 5, 3);
    drive_pwm(10, 6, 3);

    drive_pwm(10, 5, 3);
    drive_pwm(4, 4, 1);
    do_reset(3);
    drive_pwm(10, 5, 4);

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(7, 0) == 0) per = $urandom_range(215, 190);
      else                           per = $urandom_range(40, 2);
      hi = $urandom_range(per, 0);
      drive_pwm(per, hi, $urandom_range(2, 1));
    end
    drive_pwm(12, 6, 2);

    repeat (10) @(negedge clk);
    #1;
    drain_req = 1'b1;
    for (int i = 0; i < 20 && !drain_done; i++) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
